vram_arbiter: RTL and testbench
===============================

# vram_arbiter

Shares the single-port synchronous character VRAM (2048 x 8, 1-cycle read latency) between the display character fetcher and the CPU bus port. The display fetcher has absolute priority and sees an unchanged address/data path; CPU reads and writes are queued one at a time and slotted into cycles the display does not claim. Sits between the pixel/character data reader, the CPU I/O decode and the VRAM macro.

## Interface
- MAX_WAIT, 255: CPU wait cycles in ISSUE before `stall_err` sets (1..255).
- clk  in  1  system clock, all logic rising-edge.
- reset  in  1  synchronous, active-high.
- vid_req  in  1  display claims the VRAM this cycle.
- vid_addr  in  11  display address, valid when vid_req.
- vid_data  out  8  = sram_rdata (combinational pass-through).
- cpu_req  in  1  CPU access request; addr/we/wdata stable while high.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  11  CPU VRAM address.
- cpu_wdata  in  8  CPU write data.
- cpu_ack  out  1  one-cycle completion pulse (registered).
- cpu_rdata  out  8  read result (registered, held until next read completes).
- stall_err  out  1  sticky: a CPU access waited > MAX_WAIT cycles.
- sram_addr  out  11  VRAM address.
- sram_we  out  1  VRAM write enable.
- sram_wdata  out  8  VRAM write data.
- sram_rdata  in  8  VRAM read data (for address presented previous cycle).

## Operation
- Internal regs: state (IDLE, ISSUE, DATA), latched op {we, addr[10:0], wdata[7:0]}, wait_cnt[7:0].
- IDLE: if cpu_req && !cpu_ack -> latch op, wait_cnt <= 0, -> ISSUE. cpu_req in the cycle cpu_ack is high is ignored (requester is releasing); a req still high the following cycle is a new access.
- ISSUE: grant = !vid_req.
  - grant: sram_addr = latched addr, sram_we = latched we, sram_wdata = latched wdata; -> DATA.
  - no grant: stay; wait_cnt saturating +1; if wait_cnt == MAX_WAIT then stall_err <= 1.
- DATA: cpu_ack <= 1; if latched op is a read, cpu_rdata <= sram_rdata; -> IDLE. Writes leave cpu_rdata unchanged.
- All non-granted cycles: sram_addr = vid_addr, sram_we = 0, sram_wdata = latched wdata.
- vid_req is never delayed or blocked; display may issue in DATA (SRAM reads are pipelined, each consumer samples sram_rdata in its own data cycle).
- One CPU op outstanding; no queueing of a second request.
- stall_err clears only on reset.

## Timing
- Reset values: state IDLE, cpu_ack 0, cpu_rdata 8'h00, stall_err 0, wait_cnt 0, latched op 0; sram_we 0 during and after reset.
- Uncontended latency: cpu_req first high in cycle T (IDLE) -> ISSUE/SRAM access at T+1 -> DATA at T+2 -> cpu_ack high and cpu_rdata valid at T+3.
- Each cycle of vid_req during ISSUE adds exactly one cycle.
- Write lands in SRAM at the end of the grant cycle; a display read of the same address in the next cycle sees new data.
- Reset asserted mid-operation (ISSUE or DATA): pending op dropped, no write issued in or after the reset cycle, no ack produced.
- wait_cnt saturates at 255; stall_err set in the cycle after the (MAX_WAIT+1)th denied ISSUE cycle.
- vid_data has no added latency vs. direct SRAM connection.

## Test plan
- Uncontended write then read: vid_req=0; write 8'hA5 to 11'h123, then read 11'h123 -> sram_we high exactly one cycle with addr 11'h123; second op cpu_ack at T+3, cpu_rdata = 8'hA5.
- Contention: cpu_req read at T with vid_req held high T+1..T+5 -> CPU address on sram_addr only at T+6, cpu_ack at T+8; sram_addr = vid_addr every cycle T+1..T+5, sram_we never high.
- Held request: cpu_req held high across ack -> exactly one ack per 3-cycle access (no extra access on the ack cycle), next access begins the cycle after ack.
- Starvation: MAX_WAIT=4, vid_req held high 10 cycles during ISSUE -> stall_err rises after 5th denied cycle, stays high after access completes, clears only on reset.
- Reset mid-op: reset asserted in grant cycle of a write to 11'h010 -> sram_we 0 in that cycle, cpu_ack never pulses, state IDLE, cpu_rdata 8'h00, memory at 11'h010 unchanged.
- Display pass-through: vid_req every cycle with incrementing vid_addr, no CPU traffic -> sram_addr tracks vid_addr same cycle, vid_data equals sram_rdata bit-for-bit.

Source files
------------

// File: rtl/vram_arbiter_if.sv
// Bus bundle between display fetcher, CPU port, character VRAM and arbiter.
// The arbiter takes the slave view; the surrounding logic takes the master view.
interface vram_arbiter_if;
    logic        vid_req;
    logic [10:0] vid_addr;
    logic [7:0]  vid_data;
    logic        cpu_req;
    logic        cpu_we;
    logic [10:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic        stall_err;
    logic [10:0] sram_addr;
    logic        sram_we;
    logic [7:0]  sram_wdata;
    logic [7:0]  sram_rdata;

    modport master (
        output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output sram_rdata,
        input  vid_data, cpu_ack, cpu_rdata, stall_err,
        input  sram_addr, sram_we, sram_wdata
    );

    modport slave (
        input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  sram_rdata,
        output vid_data, cpu_ack, cpu_rdata, stall_err,
        output sram_addr, sram_we, sram_wdata
    );
endinterface

// File: rtl/vram_arbiter.sv
// Character VRAM arbiter: display has absolute priority, one CPU op
// at a time is slotted into cycles the display leaves free.
module vram_arbiter #(
    parameter int MAX_WAIT = 255
) (
    input logic          clk,
    input logic          reset,
    vram_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, DATA} state_t;

    state_t      state, state_next;
    logic        op_we;
    logic [10:0] op_addr;
    logic [7:0]  op_wdata;
    logic [7:0]  wait_cnt;
    logic        ack_q;
    logic [7:0]  rdata_q;
    logic        stall_q;
    logic        start;
    logic        grant;

    assign bus.vid_data  = bus.sram_rdata;
    assign bus.cpu_ack   = ack_q;
    assign bus.cpu_rdata = rdata_q;
    assign bus.stall_err = stall_q;

    always_comb begin
        state_next     = state;
        start          = 1'b0;
        grant          = 1'b0;
        bus.sram_addr  = bus.vid_addr;
        bus.sram_we    = 1'b0;
        bus.sram_wdata = op_wdata;
        unique case (state)
            // A request seen alongside ack belongs to the op just finishing
            IDLE: begin
                if (bus.cpu_req && !ack_q) begin
                    start      = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (!bus.vid_req) begin
                    grant         = 1'b1;
                    state_next    = DATA;
                    bus.sram_addr = op_addr;
                    bus.sram_we   = op_we && !reset;
                end
            end
            DATA:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            op_we    <= 1'b0;
            op_addr  <= '0;
            op_wdata <= '0;
            wait_cnt <= '0;
            ack_q    <= 1'b0;
            rdata_q  <= '0;
            stall_q  <= 1'b0;
        end else begin
            state <= state_next;
            ack_q <= (state == DATA);
            if (start) begin
                op_we    <= bus.cpu_we;
                op_addr  <= bus.cpu_addr;
                op_wdata <= bus.cpu_wdata;
                wait_cnt <= '0;
            end
            if (state == ISSUE && !grant) begin
                if (wait_cnt != 8'hFF)
                    wait_cnt <= wait_cnt + 8'd1;
                if (wait_cnt == 8'(MAX_WAIT))
                    stall_q <= 1'b1;
            end
            if (state == DATA && !op_we)
                rdata_q <= bus.sram_rdata;
        end
    end
endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboarded bench for vram_arbiter with a behavioural 2048x8 VRAM.
// Memory is preloaded with (addr[7:0] ^ 8'h5A).
module tb_vram_arbiter;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vram_arbiter_if bus();

    vram_arbiter #(.MAX_WAIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0] mem [0:2047];
    bit mem_ready = 1'b0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 2048; i++)
                mem[i] <= 8'(i) ^ 8'h5A;
            mem_ready <= 1'b1;
        end else begin
            if (bus.sram_we === 1'b1)
                mem[bus.sram_addr] <= bus.sram_wdata;
            bus.sram_rdata <= mem[bus.sram_addr];
        end
    end

    typedef struct {
        int         cyc;
        logic [7:0] rd;
    } exp_t;

    exp_t       q[$];
    int         checks = 0;
    int         errors = 0;
    int         we_cnt = 0;
    logic [7:0] last_we_data;
    bit         exp_stall = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cyc %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: counts VRAM writes and checks every ack against the queue
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.sram_we === 1'b1) begin
                we_cnt++;
                last_we_data = bus.sram_wdata;
            end
            if (bus.cpu_ack === 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack: got ack expected none (cyc %0d)",
                             cyc);
                end else begin
                    e = q.pop_front();
                    chk("ack_cycle", cyc, e.cyc);
                    chk("cpu_rdata", {24'h0, bus.cpu_rdata}, {24'h0, e.rd});
                end
            end
        end
    end

    task automatic cpu_op(input bit we, input logic [10:0] addr,
                          input logic [7:0] wdata, input logic [7:0] exp_rd,
                          input int ndeny, input int lag, input bit hold);
        int t0;
        int wb;
        bit got;
        exp_t e;
        t0 = cyc;
        wb = we_cnt;
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
        e.cyc = t0 + lag + 3 + ndeny;
        e.rd  = exp_rd;
        q.push_back(e);
        repeat (lag) begin
            tick();
            @(negedge clk);
            chk("lag_we", {31'h0, bus.sram_we}, 32'h0);
        end
        for (int k = 1; k <= ndeny; k++) begin
            tick();
            bus.vid_req  = 1'b1;
            bus.vid_addr = 11'h400 + 11'(k);
            @(negedge clk);
            chk("deny_addr", {21'h0, bus.sram_addr}, 32'h400 + 32'(k));
            chk("deny_we", {31'h0, bus.sram_we}, 32'h0);
            chk("deny_stall", {31'h0, bus.stall_err},
                {31'h0, exp_stall || k >= 6});
        end
        tick();
        bus.vid_req = 1'b0;
        @(negedge clk);
        chk("grant_addr", {21'h0, bus.sram_addr}, {21'h0, addr});
        chk("grant_we", {31'h0, bus.sram_we}, {31'h0, we});
        if (ndeny >= 5) exp_stall = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (bus.cpu_ack === 1'b1) got = 1'b1;
        end
        if (!got) begin
            errors++;
            $display("FAIL ack_timeout: got no ack expected ack (cyc %0d)", cyc);
        end
        checks++;
        if (!hold) bus.cpu_req = 1'b0;
        chk("we_count", 32'(we_cnt - wb), {31'h0, we});
        if (we) chk("we_data", {24'h0, last_we_data}, {24'h0, wdata});
        chk("stall_err", {31'h0, bus.stall_err}, {31'h0, exp_stall});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int wb;
        reset         = 1'b1;
        bus.vid_req   = 1'b0;
        bus.vid_addr  = '0;
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 11'h7FF;
        bus.cpu_wdata = 8'hFF;

        repeat (3) begin
            tick();
            @(negedge clk);
            chk("rst_we", {31'h0, bus.sram_we}, 32'h0);
            chk("rst_ack", {31'h0, bus.cpu_ack}, 32'h0);
            chk("rst_rdata", {24'h0, bus.cpu_rdata}, 32'h0);
            chk("rst_stall", {31'h0, bus.stall_err}, 32'h0);
        end
        tick();
        reset = 1'b0;
        bus.cpu_req = 1'b0;
        tick();

        // Uncontended write then read
        cpu_op(1'b1, 11'h123, 8'hA5, 8'h00, 0, 0, 1'b0);
        tick();
        cpu_op(1'b0, 11'h123, 8'h00, 8'hA5, 0, 0, 1'b0);
        tick();

        // Display pass-through
        for (int i = 0; i < 8; i++) begin
            tick();
            bus.vid_req  = 1'b1;
            bus.vid_addr = 11'h200 + 11'(i);
            @(negedge clk);
            chk("pass_addr", {21'h0, bus.sram_addr}, 32'h200 + 32'(i));
            chk("pass_data", {24'h0, bus.vid_data}, {24'h0, bus.sram_rdata});
            if (i > 0)
                chk("pass_mem", {24'h0, bus.vid_data},
                    {24'h0, 8'(i - 1) ^ 8'h5A});
        end
        tick();
        bus.vid_req = 1'b0;
        tick();

        // Contention: 4 denials stays under the stall limit, 5 crosses it
        cpu_op(1'b0, 11'h301, 8'h00, 8'h5B, 4, 0, 1'b0);
        tick();
        cpu_op(1'b0, 11'h300, 8'h00, 8'h5A, 5, 0, 1'b0);
        tick();

        // Held request: second access starts the cycle after ack
        cpu_op(1'b1, 11'h050, 8'h3C, 8'h5A, 0, 0, 1'b1);
        cpu_op(1'b0, 11'h050, 8'h00, 8'h3C, 0, 1, 1'b0);
        tick();

        // Reset in the grant cycle of a write
        wb = we_cnt;
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 11'h010;
        bus.cpu_wdata = 8'hEE;
        tick();
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_we", {31'h0, bus.sram_we}, 32'h0);
        tick();
        reset = 1'b0;
        bus.cpu_req = 1'b0;
        exp_stall = 1'b0;
        @(negedge clk);
        chk("midrst_rdata", {24'h0, bus.cpu_rdata}, 32'h0);
        chk("midrst_stall", {31'h0, bus.stall_err}, 32'h0);
        repeat (4) tick();
        chk("midrst_wecnt", 32'(we_cnt - wb), 32'h0);
        cpu_op(1'b0, 11'h010, 8'h00, 8'h4A, 0, 0, 1'b0);
        tick();

        // Starvation: sticky stall until reset
        cpu_op(1'b0, 11'h302, 8'h00, 8'h58, 10, 0, 1'b0);
        repeat (3) tick();
        chk("stall_sticky", {31'h0, bus.stall_err}, 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_stall = 1'b0;
        @(negedge clk);
        chk("stall_cleared", {31'h0, bus.stall_err}, 32'h0);
        tick();
        chk("queue_empty", 32'(q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
